sliding_window_buffer: RTL

SLIDING_WINDOW_BUFFER -- requirements
Module: sliding_window_buffer

---
 rtl/sliding_window_buffer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sliding_window_buffer.sv
// Streams raster pixels through KSIZE-1 line buffers and emits KSIZE x KSIZE windows.
// Define SWB_CFG_CHECK_EN to add frame-dimension checking and the cfg_err output.

module sliding_window_buffer #(
  parameter int DATA_W    = 8,
  parameter int KSIZE     = 3,
  parameter int MAX_WIDTH = 2048
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [12:0]                     image_width,
  input  logic [10:0]                     image_height,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               data_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [KSIZE*KSIZE*DATA_W-1:0]   window_out,
  output logic                            busy,
  output logic                            frame_done
`ifdef SWB_CFG_CHECK_EN
  ,
  output logic                            cfg_err
`endif
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int EW = KSIZE * KSIZE * DATA_W;

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [12:0]         r_col;
  logic [12:0]         r_width;
  logic [12:0]         w_width;
  logic [10:0]         r_row;
  logic [10:0]         r_height;
  logic [10:0]         w_height;
  logic                r_busy;
  logic [EW-1:0]       r_win;
  logic                w_first;
  logic                w_accept;
  logic                w_out_fire;
  logic                w_emit;
  logic                w_col_end;
  logic                w_row_end;
  logic                w_last;
  logic                w_err;
  logic [AW-1:0]       w_addr;
  logic [DATA_W-1:0]   w_col [KSIZE];
  logic [DATA_W-1:0]   r_lb  [KSIZE-1][MAX_WIDTH];

`ifdef SWB_CFG_CHECK_EN
  logic r_cfg_err;
  logic w_bad_dims;

  assign w_bad_dims = (image_width < 13'(KSIZE)) || (image_width > 13'(MAX_WIDTH)) ||
                      (image_height < 11'(KSIZE));
  assign w_err      = r_cfg_err;
  assign cfg_err    = r_cfg_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_err <= 1'b0;
    end else if (clear) begin
      r_cfg_err <= 1'b0;
    end else if (w_accept && w_first && w_bad_dims) begin
      r_cfg_err <= 1'b1;
    end
  end
`else
  assign w_err = 1'b0;
`endif

  // A pending window is exactly "not FILL", so out_valid decodes straight from the state.
  assign out_valid  = (r_state != FILL);
  assign in_ready   = !w_err && !(out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready && !clear;
  assign w_out_fire = out_valid && out_ready && !clear;
  assign frame_done = (r_state == FLUSH) && w_out_fire;
  assign busy       = r_busy;
  assign window_out = r_win;

  // Dimensions come from the ports only on the frame's first pixel, else from the latch.
  assign w_first   = (r_col == '0) && (r_row == '0);
  assign w_width   = w_first ? image_width  : r_width;
  assign w_height  = w_first ? image_height : r_height;
  assign w_col_end = (r_col == w_width - 13'd1);
  assign w_row_end = (r_row == w_height - 11'd1);
  assign w_emit    = (r_row >= 11'(KSIZE-1)) && (r_col >= 13'(KSIZE-1));
  assign w_last    = w_col_end && w_row_end;
  assign w_addr    = r_col[AW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = FILL;
    end else if (w_accept && w_emit) begin
      w_state_nxt = w_last ? FLUSH : STREAM;
    end else if (w_out_fire) begin
      w_state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col    <= '0;
      r_row    <= '0;
      r_width  <= '0;
      r_height <= '0;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_first) begin
        r_width  <= image_width;
        r_height <= image_height;
      end
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 11'd1;
      end else begin
        r_col <= r_col + 13'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
    end else if (clear) begin
      r_busy <= 1'b0;
    end else if (w_accept && w_first) begin
      r_busy <= 1'b1;
    end else if (frame_done) begin
      r_busy <= 1'b0;
    end
  end

  // Line buffers form a vertical shift chain per column: r_lb[k] holds line r-1-k.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][w_addr] <= data_in;
      for (int unsigned k = 1; k < KSIZE-1; k++) begin
        r_lb[k][w_addr] <= r_lb[k-1][w_addr];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < KSIZE-1; i++) begin
      w_col[i] = r_lb[KSIZE-2-i][w_addr];
    end
    w_col[KSIZE-1] = data_in;
  end

  // The window shifts left one column per accepted pixel; it only moves on input
  // acceptance, which a stalled output blocks, so it stays stable while out_valid waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win <= '0;
    end else if (w_accept) begin
      for (int unsigned i = 0; i < KSIZE; i++) begin
        for (int unsigned j = 0; j < KSIZE-1; j++) begin
          r_win[(i*KSIZE+j)*DATA_W +: DATA_W] <= r_win[(i*KSIZE+j+1)*DATA_W +: DATA_W];
        end
        r_win[(i*KSIZE+KSIZE-1)*DATA_W +: DATA_W] <= w_col[i];
      end
    end
  end

endmodule
